// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, stall hold and flush bubble.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH    = 4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic                      ValidIn,
    input  logic [31:0]               Instruction,
    input  logic [31:0]               PCPlus4In,
    input  logic [DATA_WIDTH-1:0]     ReadData1,
    input  logic [DATA_WIDTH-1:0]     ReadData2,
    input  logic                      WBRegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] WBWriteRegister,
    input  logic [DATA_WIDTH-1:0]     WBWriteData,
    input  logic                      ExtOp,
    input  logic                      RegWriteIn,
    input  logic                      MemReadIn,
    input  logic                      MemWriteIn,
    input  logic                      MemToRegIn,
    input  logic                      ALUSrcIn,
    input  logic                      RegDstIn,
    input  logic [ALUOP_WIDTH-1:0]    ALUOpIn,
    output logic                      ValidOut,
    output logic [DATA_WIDTH-1:0]     RsData,
    output logic [DATA_WIDTH-1:0]     RtData,
    output logic [DATA_WIDTH-1:0]     ImmExt,
    output logic [REG_ADDR_WIDTH-1:0] Rs,
    output logic [REG_ADDR_WIDTH-1:0] Rt,
    output logic [REG_ADDR_WIDTH-1:0] Rd,
    output logic [4:0]                Shamt,
    output logic [5:0]                Funct,
    output logic [31:0]               PCPlus4Out,
    output logic                      RegWriteOut,
    output logic                      MemReadOut,
    output logic                      MemWriteOut,
    output logic                      MemToRegOut,
    output logic                      ALUSrcOut,
    output logic                      RegDstOut,
    output logic [ALUOP_WIDTH-1:0]    ALUOpOut
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]               StallCycles,
    output logic [31:0]               BubbleCount
`endif
);

    function automatic logic [DATA_WIDTH-1:0] ext_imm(input logic [15:0] imm, input logic sgn);
        ext_imm = {{(DATA_WIDTH-16){sgn & imm[15]}}, imm};
    endfunction

    logic                      r_valid;
    logic [DATA_WIDTH-1:0]     r_rs_data;
    logic [DATA_WIDTH-1:0]     r_rt_data;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic [REG_ADDR_WIDTH-1:0] r_rs;
    logic [REG_ADDR_WIDTH-1:0] r_rt;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [4:0]                r_shamt;
    logic [5:0]                r_funct;
    logic [31:0]               r_pc4;
    logic [5:0]                r_ctrl;
    logic [ALUOP_WIDTH-1:0]    r_aluop;

    logic [REG_ADDR_WIDTH-1:0] w_rs_idx;
    logic [REG_ADDR_WIDTH-1:0] w_rt_idx;
    logic [DATA_WIDTH-1:0]     w_rs_data;
    logic [DATA_WIDTH-1:0]     w_rt_data;
    logic                      w_hold_rs_hit;
    logic                      w_hold_rt_hit;

    assign w_rs_idx = Instruction[25:21];
    assign w_rt_idx = Instruction[20:16];

    // The register file commits WB at this same edge, so its read ports still show stale data.
    assign w_rs_data = (WBRegWrite && (WBWriteRegister == w_rs_idx) && (w_rs_idx != '0))
                       ? WBWriteData : ReadData1;
    assign w_rt_data = (WBRegWrite && (WBWriteRegister == w_rt_idx) && (w_rt_idx != '0))
                       ? WBWriteData : ReadData2;

    assign w_hold_rs_hit = r_valid && WBRegWrite && (WBWriteRegister == r_rs) && (r_rs != '0);
    assign w_hold_rt_hit = r_valid && WBRegWrite && (WBWriteRegister == r_rt) && (r_rt != '0);

    always_ff @(posedge Clock) begin
        if (Reset || Flush) begin
            r_valid   <= 1'b0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_shamt   <= '0;
            r_funct   <= '0;
            r_pc4     <= '0;
            r_ctrl    <= '0;
            r_aluop   <= '0;
        end else if (Stall) begin
            // A held entry must not lose a result written back while it waits.
            if (w_hold_rs_hit) r_rs_data <= WBWriteData;
            if (w_hold_rt_hit) r_rt_data <= WBWriteData;
        end else begin
            r_valid   <= ValidIn;
            r_rs_data <= w_rs_data;
            r_rt_data <= w_rt_data;
            r_imm     <= ext_imm(Instruction[15:0], ExtOp);
            r_rs      <= w_rs_idx;
            r_rt      <= w_rt_idx;
            r_rd      <= Instruction[15:11];
            r_shamt   <= Instruction[10:6];
            r_funct   <= Instruction[5:0];
            r_pc4     <= PCPlus4In;
            r_ctrl    <= ValidIn ? {RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn, ALUSrcIn, RegDstIn}
                                 : 6'b0;
            r_aluop   <= ValidIn ? ALUOpIn : '0;
        end
    end

    assign ValidOut    = r_valid;
    assign RsData      = r_rs_data;
    assign RtData      = r_rt_data;
    assign ImmExt      = r_imm;
    assign Rs          = r_rs;
    assign Rt          = r_rt;
    assign Rd          = r_rd;
    assign Shamt       = r_shamt;
    assign Funct       = r_funct;
    assign PCPlus4Out  = r_pc4;
    assign RegWriteOut = r_ctrl[5];
    assign MemReadOut  = r_ctrl[4];
    assign MemWriteOut = r_ctrl[3];
    assign MemToRegOut = r_ctrl[2];
    assign ALUSrcOut   = r_ctrl[1];
    assign RegDstOut   = r_ctrl[0];
    assign ALUOpOut    = r_aluop;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (Stall && !Flush) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (Flush)           r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign StallCycles = r_stall_cnt;
    assign BubbleCount = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage (load/bypass/imm vectors plus
// stall, flush and reset sequences; counter checks when ID_EX_PERF_CNT_EN is defined).
module tb_id_ex_stage;

    logic        Clock = 1'b0;
    logic        Reset, Stall, Flush, ValidIn;
    logic [31:0] Instruction, PCPlus4In, ReadData1, ReadData2;
    logic        WBRegWrite;
    logic [4:0]  WBWriteRegister;
    logic [31:0] WBWriteData;
    logic        ExtOp;
    logic        RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn, ALUSrcIn, RegDstIn;
    logic [3:0]  ALUOpIn;
    logic        ValidOut;
    logic [31:0] RsData, RtData, ImmExt, PCPlus4Out;
    logic [4:0]  Rs, Rt, Rd, Shamt;
    logic [5:0]  Funct;
    logic        RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut, ALUSrcOut, RegDstOut;
    logic [3:0]  ALUOpOut;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] StallCycles, BubbleCount;
`endif

    int n_vec = 0;
    int n_err = 0;

    id_ex_stage dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
        .Instruction(Instruction), .PCPlus4In(PCPlus4In),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .WBRegWrite(WBRegWrite), .WBWriteRegister(WBWriteRegister), .WBWriteData(WBWriteData),
        .ExtOp(ExtOp),
        .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .MemToRegIn(MemToRegIn), .ALUSrcIn(ALUSrcIn), .RegDstIn(RegDstIn), .ALUOpIn(ALUOpIn),
        .ValidOut(ValidOut), .RsData(RsData), .RtData(RtData), .ImmExt(ImmExt),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct), .PCPlus4Out(PCPlus4Out),
        .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
        .MemToRegOut(MemToRegOut), .ALUSrcOut(ALUSrcOut), .RegDstOut(RegDstOut),
        .ALUOpOut(ALUOpOut)
`ifdef ID_EX_PERF_CNT_EN
        , .StallCycles(StallCycles), .BubbleCount(BubbleCount)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        wbwe;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic        extop;
        logic        vin;
        logic [31:0] pc;
        logic [4:0]  ers;
        logic [4:0]  ert;
        logic [4:0]  erd;
        logic [31:0] ersd;
        logic [31:0] ertd;
        logic [31:0] eimm;
        logic        evalid;
        logic        eregw;
        logic [3:0]  ealu;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input vec_t v);
        Instruction     = v.instr;
        ReadData1       = v.rd1;
        ReadData2       = v.rd2;
        WBRegWrite      = v.wbwe;
        WBWriteRegister = v.wbreg;
        WBWriteData     = v.wbdata;
        ExtOp           = v.extop;
        ValidIn         = v.vin;
        PCPlus4In       = v.pc;
        RegWriteIn = 1'b1; MemReadIn = 1'b0; MemWriteIn = 1'b0;
        MemToRegIn = 1'b0; ALUSrcIn = 1'b1; RegDstIn = 1'b1; ALUOpIn = 4'h2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"},  {31'b0, ValidOut}, 32'd0);
        chk({tag, ".rsdata"}, RsData, 32'd0);
        chk({tag, ".rtdata"}, RtData, 32'd0);
        chk({tag, ".imm"},    ImmExt, 32'd0);
        chk({tag, ".fields"}, {12'b0, Rs, Rt, Rd, Shamt}, 32'd0);
        chk({tag, ".funct"},  {26'b0, Funct}, 32'd0);
        chk({tag, ".pc4"},    PCPlus4Out, 32'd0);
        chk({tag, ".ctrl"},   {22'b0, RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut,
                               ALUSrcOut, RegDstOut, ALUOpOut}, 32'd0);
    endtask

    initial begin
        //                instr         rd1          rd2   we reg  wbdata    ext vin pc            rs  rt  rd   rsd          rtd   imm          v  rw alu
        vecs[0] = '{32'h012A4020, 32'd9,      32'd10,  0, 5'd0,  32'h0,      0, 1, 32'h0000_0404, 9,  10, 8,  32'd9,       32'd10, 32'h0000_4020, 1, 1, 4'h2};
        vecs[1] = '{32'h012A4020, 32'd9,      32'd10,  1, 5'd9,  32'hDEADBEEF,0, 1, 32'h0000_0408, 9,  10, 8,  32'hDEADBEEF, 32'd10, 32'h0000_4020, 1, 1, 4'h2};
        vecs[2] = '{32'h000A4020, 32'h123,    32'd10,  1, 5'd0,  32'hCAFE,   0, 1, 32'h0000_040C, 0,  10, 8,  32'h123,     32'd10, 32'h0000_4020, 1, 1, 4'h2};
        vecs[3] = '{32'h21098004, 32'h100,    32'h200, 0, 5'd0,  32'h0,      1, 1, 32'h0000_0410, 8,  9,  16, 32'h100,     32'h200, 32'hFFFF_8004, 1, 1, 4'h2};
        vecs[4] = '{32'h21098004, 32'h100,    32'h200, 0, 5'd0,  32'h0,      0, 1, 32'h0000_0414, 8,  9,  16, 32'h100,     32'h200, 32'h0000_8004, 1, 1, 4'h2};
        vecs[5] = '{32'h012A4020, 32'd1,      32'd2,   0, 5'd0,  32'h0,      0, 0, 32'h0000_0418, 9,  10, 8,  32'd1,       32'd2,  32'h0000_4020, 0, 0, 4'h0};
        vecs[6] = '{32'h012A4020, 32'd9,      32'd10,  1, 5'd10, 32'h77,     0, 1, 32'h0000_041C, 9,  10, 8,  32'd9,       32'h77, 32'h0000_4020, 1, 1, 4'h2};
        vecs[7] = '{32'h01294020, 32'd9,      32'd9,   1, 5'd9,  32'hAA,     0, 1, 32'h0000_0420, 9,  9,  8,  32'hAA,      32'hAA, 32'h0000_4020, 1, 1, 4'h2};
        vecs[8] = '{32'h012A4020, 32'd9,      32'd10,  0, 5'd9,  32'hBAD,    0, 1, 32'h0000_0424, 9,  10, 8,  32'd9,       32'd10, 32'h0000_4020, 1, 1, 4'h2};

        // Reset for two cycles with arbitrary inputs
        Stall = 1'b1; Flush = 1'b0; Reset = 1'b1;
        drive(vecs[1]);
        tick();
        tick();
        chk_all_zero("reset");
        Reset = 1'b0; Stall = 1'b0;

        // Table of single-cycle loads
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("v%0d.valid", i),  {31'b0, ValidOut}, {31'b0, vecs[i].evalid});
            chk($sformatf("v%0d.regw", i),   {31'b0, RegWriteOut}, {31'b0, vecs[i].eregw});
            chk($sformatf("v%0d.aluop", i),  {28'b0, ALUOpOut}, {28'b0, vecs[i].ealu});
            chk($sformatf("v%0d.regs", i),   {17'b0, Rs, Rt, Rd}, {17'b0, vecs[i].ers, vecs[i].ert, vecs[i].erd});
            chk($sformatf("v%0d.rsdata", i), RsData, vecs[i].ersd);
            chk($sformatf("v%0d.rtdata", i), RtData, vecs[i].ertd);
            chk($sformatf("v%0d.imm", i),    ImmExt, vecs[i].eimm);
            chk($sformatf("v%0d.pc4", i),    PCPlus4Out, vecs[i].pc);
        end
        chk("add.funct", {26'b0, Funct}, 32'h20);

        // Stall three cycles; WB writes reg 10 with 0x55 in the second
        drive(vecs[0]);
        tick();
        Stall = 1'b1;
        drive(vecs[3]);
        WBRegWrite = 1'b0;
        for (int c = 0; c < 3; c++) begin
            WBRegWrite = (c == 1); WBWriteRegister = 5'd10; WBWriteData = 32'h55;
            tick();
            chk($sformatf("stall%0d.rsdata", c), RsData, 32'd9);
            chk($sformatf("stall%0d.rtdata", c), RtData, (c == 0) ? 32'd10 : 32'h55);
            chk($sformatf("stall%0d.regs", c), {17'b0, Rs, Rt, Rd}, {17'b0, 5'd9, 5'd10, 5'd8});
            chk($sformatf("stall%0d.pc4", c), PCPlus4Out, 32'h0000_0404);
            chk($sformatf("stall%0d.imm", c), ImmExt, 32'h0000_4020);
            chk($sformatf("stall%0d.valid", c), {31'b0, ValidOut}, 32'd1);
        end
        Stall = 1'b0;
        drive(vecs[4]);
        tick();
        chk("resume.rsdata", RsData, 32'h100);
        chk("resume.imm", ImmExt, 32'h0000_8004);
        chk("resume.pc4", PCPlus4Out, 32'h0000_0414);

        // Flush together with stall produces a bubble
        drive(vecs[0]);
        Flush = 1'b1; Stall = 1'b1;
        tick();
        chk_all_zero("flush_stall");
        Flush = 1'b0; Stall = 1'b0;

        // Reset during a stall
        drive(vecs[1]);
        tick();
        Stall = 1'b1;
        tick();
        chk("prereset.rsdata", RsData, 32'hDEADBEEF);
        Reset = 1'b1;
        tick();
        chk_all_zero("reset_stall");
        Reset = 1'b0; Stall = 1'b0;
        drive(vecs[0]);
        tick();
        chk("postreset.rsdata", RsData, 32'd9);
        chk("postreset.valid", {31'b0, ValidOut}, 32'd1);

`ifdef ID_EX_PERF_CNT_EN
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("perf.reset_stall", StallCycles, 32'd0);
        Stall = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        Flush = 1'b1;
        tick();
        Stall = 1'b0;
        tick();
        Flush = 1'b0;
        tick();
        chk("perf.stall_cycles", StallCycles, 32'd5);
        chk("perf.bubble_count", BubbleCount, 32'd2);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("perf.clr_stall", StallCycles, 32'd0);
        chk("perf.clr_bubble", BubbleCount, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
